fu_issue_scheduler: RTL and testbench

//  Buffers decoded instructions from the decode stage and issues each one to a

---
 rtl/fu_issue_scheduler.sv | 166 ++++++++++++++++
 tb/tb_fu_issue_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler
// Buffers decoded instructions in a small FIFO and issues the head entry to a
// free reservation station over the shared issue bus {fu, RB_index, inst}.
// A one-cycle "reserved" mask covers the gap between an issue and the target
// RS raising its busy flag, so no RS is ever issued to twice.
// Optional build macro: ROUND_ROBIN_EN selects circular round-robin RS
// selection; when it is undefined the lowest-numbered candidate RS wins.
module fu_issue_scheduler #(
    parameter int FU_NUM    = 7,
    parameter int FU_INDEX  = 3,
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 4,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_inst,
    input  logic [RB_INDEX-1:0]  in_rb_index,
    input  logic [FU_NUM-1:0]    in_fu_mask,
    input  logic [FU_NUM-1:0]    busy_out,
    input  logic                 flush,
    output logic [FU_INDEX-1:0]  fu,
    output logic [RB_INDEX-1:0]  RB_index,
    output logic [WORD_SIZE-1:0] inst,
    output logic [15:0]          stall_cnt
);

    localparam logic [FU_INDEX-1:0] FU_NONE = '1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage; the head entry is read combinationally every cycle
    logic [WORD_SIZE-1:0] inst_mem [DEPTH];
    logic [RB_INDEX-1:0]  rb_mem   [DEPTH];
    logic [FU_NUM-1:0]    mask_mem [DEPTH];

    logic [PTR_W-1:0]     head_reg;
    logic [PTR_W-1:0]     tail_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [FU_NUM-1:0]    reserved_reg;
    logic [FU_INDEX-1:0]  fu_reg;
    logic [RB_INDEX-1:0]  rb_reg;
    logic [WORD_SIZE-1:0] inst_reg;
    logic [15:0]          stall_reg;

    logic                 head_valid;
    logic [FU_NUM-1:0]    head_mask;
    logic [FU_NUM-1:0]    cand;
    logic                 push;
    logic                 issue_fire;
    logic                 stall_evt;
    logic [FU_INDEX-1:0]  sel_idx;
    logic                 sel_found;

    assign head_valid = (count_reg != '0);
    assign head_mask  = mask_mem[head_reg];
    assign in_ready   = (count_reg < CNT_W'(DEPTH));
    assign push       = in_valid && in_ready && !flush;
    assign issue_fire = sel_found && !flush;
    assign stall_evt  = head_valid && (cand == '0) && !flush;

    // Per-RS candidate: head can use it, it is idle, and not just issued to
    generate
        for (genvar gi = 0; gi < FU_NUM; gi++) begin : g_cand
            assign cand[gi] = head_valid & head_mask[gi] & ~busy_out[gi] & ~reserved_reg[gi];
        end
    endgenerate

`ifdef ROUND_ROBIN_EN
    logic [FU_INDEX-1:0] rr_ptr_reg;

    // Circular search for the first candidate at or above the rr pointer
    always_comb begin
        int pos;
        sel_found = 1'b0;
        sel_idx   = '0;
        pos       = 0;
        for (int k = 0; k < FU_NUM; k++) begin
            pos = int'(rr_ptr_reg) + k;
            if (pos >= FU_NUM) begin
                pos = pos - FU_NUM;
            end
            if (!sel_found && cand[pos]) begin
                sel_found = 1'b1;
                sel_idx   = FU_INDEX'(pos);
            end
        end
    end

    // Pointer moves just past the RS that was issued to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg <= '0;
        end else if (issue_fire) begin
            rr_ptr_reg <= (int'(sel_idx) == FU_NUM - 1) ? '0 : sel_idx + FU_INDEX'(1);
        end
    end
`else
    // Fixed priority: scan downward so the lowest set candidate wins
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = FU_NUM - 1; k >= 0; k--) begin
            if (cand[k]) begin
                sel_found = 1'b1;
                sel_idx   = FU_INDEX'(k);
            end
        end
    end
`endif

    // FIFO write port; contents need no reset because count gates validity
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail_reg] <= in_inst;
            rb_mem[tail_reg]   <= in_rb_index;
            mask_mem[tail_reg] <= in_fu_mask;
        end
    end

    // FIFO pointers, issue bus registers, reservation mask and stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            reserved_reg <= '0;
            fu_reg       <= FU_NONE;
            rb_reg       <= '0;
            inst_reg     <= '0;
            stall_reg    <= '0;
        end else if (flush) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            reserved_reg <= '0;
            fu_reg       <= FU_NONE;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (issue_fire) begin
                head_reg     <= head_reg + PTR_W'(1);
                fu_reg       <= sel_idx;
                rb_reg       <= rb_mem[head_reg];
                inst_reg     <= inst_mem[head_reg];
                reserved_reg <= FU_NUM'(1) << sel_idx;
            end else begin
                fu_reg       <= FU_NONE;
                reserved_reg <= '0;
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(issue_fire);
            if (stall_evt && (stall_reg != 16'hFFFF)) begin
                stall_reg <= stall_reg + 16'd1;
            end
        end
    end

    assign fu        = fu_reg;
    assign RB_index  = rb_reg;
    assign inst      = inst_reg;
    assign stall_cnt = stall_reg;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// tb_fu_issue_scheduler
// Directed vector table plus randomized traffic against a queue-based
// reference model of the issue scheduler. Define ROUND_ROBIN_EN to match
// the RTL build when checking the round-robin variant.
module tb_fu_issue_scheduler;

    localparam int FU_NUM = 7;
    localparam int FU_NONE = 7;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [3:0]  in_rb_index;
    logic [6:0]  in_fu_mask;
    logic [6:0]  busy_out;
    logic        flush;
    logic [2:0]  fu;
    logic [3:0]  RB_index;
    logic [31:0] inst;
    logic [15:0] stall_cnt;

    fu_issue_scheduler #(
        .FU_NUM(7), .FU_INDEX(3), .WORD_SIZE(32), .RB_INDEX(4), .DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_inst(in_inst),
        .in_rb_index(in_rb_index),
        .in_fu_mask(in_fu_mask),
        .busy_out(busy_out),
        .flush(flush),
        .fu(fu),
        .RB_index(RB_index),
        .inst(inst),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state: queue of buffered instructions
    typedef struct {
        logic [31:0] inst;
        logic [3:0]  rb;
        logic [6:0]  mask;
    } entry_t;

    entry_t      mq[$];
    int          m_res;
    int          m_rr;
    int          m_stall;
    int          m_fu;
    logic [3:0]  m_rb;
    logic [31:0] m_inst;

    typedef struct {
        logic       v;
        logic [3:0] rb;
        logic [6:0] mask;
        logic [6:0] busy;
        logic       fl;
        int         efu;
        int         erb;
        logic       erdy;
        int         estall;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_res   = -1;
        m_rr    = 0;
        m_stall = 0;
        m_fu    = FU_NONE;
        m_rb    = '0;
        m_inst  = '0;
    endtask

    // One clock of scheduler behaviour from the rules: flush wins, otherwise
    // the head goes to an idle, unreserved RS it can use, else it stalls.
    task automatic model_step(input logic v, input logic [31:0] wi, input logic [3:0] rb,
                              input logic [6:0] mask, input logic [6:0] busy, input logic fl);
        bit can_push;
        int pick;
        int k;
        can_push = v && (mq.size() < DEPTH) && !fl;
        pick = -1;
        if (fl) begin
            mq.delete();
            m_fu  = FU_NONE;
            m_res = -1;
        end else begin
            if (mq.size() > 0) begin
                for (int j = 0; j < FU_NUM; j++) begin
`ifdef ROUND_ROBIN_EN
                    k = (m_rr + j) % FU_NUM;
`else
                    k = j;
`endif
                    if (pick < 0 && mq[0].mask[k] && !busy[k] && k != m_res) begin
                        pick = k;
                    end
                end
                if (pick >= 0) begin
                    m_rb   = mq[0].rb;
                    m_inst = mq[0].inst;
                    void'(mq.pop_front());
                    m_rr   = (pick + 1) % FU_NUM;
                end else if (m_stall < 65535) begin
                    m_stall++;
                end
            end
            m_fu  = (pick >= 0) ? pick : FU_NONE;
            m_res = pick;
            if (can_push) begin
                entry_t e;
                e.inst = wi;
                e.rb   = rb;
                e.mask = mask;
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_model();
        chk("fu", 32'(fu), 32'(m_fu));
        chk("rb_index", 32'(RB_index), 32'(m_rb));
        chk("inst", inst, m_inst);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    endtask

    // Apply one cycle of inputs, step the model at the edge, compare after it
    task automatic cycle(input logic v, input logic [31:0] wi, input logic [3:0] rb,
                         input logic [6:0] mask, input logic [6:0] busy, input logic fl);
        in_valid    = v;
        in_inst     = wi;
        in_rb_index = rb;
        in_fu_mask  = mask;
        busy_out    = busy;
        flush       = fl;
        @(posedge clk);
        model_step(v, wi, rb, mask, busy, fl);
        #1;
        cyc++;
        $display("cyc %0d v=%0b rb=%0d mask=%b busy=%b fl=%0b -> fu=%0d rb=%0d rdy=%0b stall=%0d",
                 cyc, v, rb, mask, busy, fl, fu, RB_index, in_ready, stall_cnt);
        check_model();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'd0,  7'b0000000, 7'b0000000, 1'b0, 7, 0,  1'b1, 0};
        tbl[1]  = '{1'b1, 4'd5,  7'b0000100, 7'b0000000, 1'b0, 7, 0,  1'b1, 0};
        tbl[2]  = '{1'b0, 4'd0,  7'b0000000, 7'b0000000, 1'b0, 2, 5,  1'b1, 0};
        tbl[3]  = '{1'b0, 4'd0,  7'b0000000, 7'b0000000, 1'b0, 7, 5,  1'b1, 0};
        tbl[4]  = '{1'b1, 4'd1,  7'b0000001, 7'b0000000, 1'b0, 7, 5,  1'b1, 0};
        tbl[5]  = '{1'b1, 4'd2,  7'b0000001, 7'b0000000, 1'b0, 0, 1,  1'b1, 0};
        tbl[6]  = '{1'b0, 4'd0,  7'b0000000, 7'b0000001, 1'b0, 7, 1,  1'b1, 1};
        tbl[7]  = '{1'b0, 4'd0,  7'b0000000, 7'b0000001, 1'b0, 7, 1,  1'b1, 2};
        tbl[8]  = '{1'b0, 4'd0,  7'b0000000, 7'b0000000, 1'b0, 0, 2,  1'b1, 2};
        tbl[9]  = '{1'b0, 4'd0,  7'b0000000, 7'b0000001, 1'b0, 7, 2,  1'b1, 2};
        tbl[10] = '{1'b1, 4'd8,  7'b0001000, 7'b1111111, 1'b0, 7, 2,  1'b1, 2};
        tbl[11] = '{1'b1, 4'd9,  7'b0001000, 7'b1111111, 1'b0, 7, 2,  1'b1, 3};
        tbl[12] = '{1'b1, 4'd10, 7'b0001000, 7'b1111111, 1'b0, 7, 2,  1'b1, 4};
        tbl[13] = '{1'b1, 4'd11, 7'b0001000, 7'b1111111, 1'b0, 7, 2,  1'b0, 5};
        tbl[14] = '{1'b1, 4'd12, 7'b0001000, 7'b1111111, 1'b0, 7, 2,  1'b0, 6};
        tbl[15] = '{1'b0, 4'd0,  7'b0000000, 7'b1110111, 1'b0, 3, 8,  1'b1, 6};
        tbl[16] = '{1'b1, 4'd13, 7'b0001000, 7'b0000000, 1'b1, 7, 8,  1'b1, 6};
        tbl[17] = '{1'b0, 4'd0,  7'b0000000, 7'b0000000, 1'b0, 7, 8,  1'b1, 6};
        tbl[18] = '{1'b0, 4'd0,  7'b0000000, 7'b0000000, 1'b0, 7, 8,  1'b1, 6};
        tbl[19] = '{1'b1, 4'd12, 7'b0000011, 7'b0000000, 1'b0, 7, 8,  1'b1, 6};
        tbl[20] = '{1'b1, 4'd13, 7'b0000011, 7'b0000000, 1'b0, 0, 12, 1'b1, 6};
        tbl[21] = '{1'b1, 4'd14, 7'b0000011, 7'b0000000, 1'b0, 1, 13, 1'b1, 6};
        tbl[22] = '{1'b1, 4'd15, 7'b0000011, 7'b0000000, 1'b0, 0, 14, 1'b1, 6};
        tbl[23] = '{1'b0, 4'd0,  7'b0000000, 7'b0000000, 1'b0, 1, 15, 1'b1, 6};
        tbl[24] = '{1'b0, 4'd0,  7'b0000000, 7'b0000000, 1'b0, 7, 15, 1'b1, 6};

        // Reset held low with a valid instruction presented: nothing enters
        reset       = 1'b0;
        in_valid    = 1'b1;
        in_inst     = 32'hDEAD_BEEF;
        in_rb_index = 4'd9;
        in_fu_mask  = 7'b0000001;
        busy_out    = '0;
        flush       = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            $display("reset cyc %0d fu=%0d rdy=%0b stall=%0d", i, fu, in_ready, stall_cnt);
            chk("reset_fu", 32'(fu), 32'd7);
            chk("reset_ready", 32'(in_ready), 32'd1);
            chk("reset_stall", 32'(stall_cnt), 32'd0);
        end
        chk("reset_rb", 32'(RB_index), 32'd0);
        chk("reset_inst", inst, 32'd0);
        reset    = 1'b1;
        in_valid = 1'b0;

        // Directed vectors: single issue, double-issue guard, full, flush, policy
        for (int i = 0; i < 25; i++) begin
            cycle(tbl[i].v, {28'hA5A5A5A, tbl[i].rb}, tbl[i].rb, tbl[i].mask, tbl[i].busy, tbl[i].fl);
            chk("tbl_fu", 32'(fu), 32'(tbl[i].efu));
            chk("tbl_rb", 32'(RB_index), 32'(tbl[i].erb));
            chk("tbl_ready", 32'(in_ready), 32'(tbl[i].erdy));
            chk("tbl_stall", 32'(stall_cnt), 32'(tbl[i].estall));
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic       rv;
            logic       rf;
            logic [6:0] rm;
            logic [6:0] rbz;
            rv  = ($urandom_range(0, 9) < 7);
            rf  = ($urandom_range(0, 19) == 0);
            rm  = 7'($urandom_range(1, 127));
            rbz = 7'($urandom) & 7'($urandom);
            cycle(rv, $urandom, 4'($urandom), rm, rbz, rf);
        end

        // Reset asserted while an issue is on the bus: fu drops at once
        cycle(1'b0, 32'd0, 4'd0, 7'd0, 7'd0, 1'b1);
        cycle(1'b1, 32'h1234_5678, 4'd3, 7'b0010000, 7'd0, 1'b0);
        cycle(1'b0, 32'd0, 4'd0, 7'd0, 7'd0, 1'b0);
        chk("pre_reset_fu", 32'(fu), 32'd4);
        reset = 1'b0;
        #1;
        $display("async reset fu=%0d rdy=%0b stall=%0d", fu, in_ready, stall_cnt);
        chk("async_reset_fu", 32'(fu), 32'd7);
        chk("async_reset_stall", 32'(stall_cnt), 32'd0);
        chk("async_reset_inst", inst, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle(1'b0, 32'd0, 4'd0, 7'd0, 7'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
